load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the word-addressed data RAM port (addr/read/write[3:0] strobes/data in/out).
//  Takes RV32I load/store requests from the core and drives RAM beats.
//  Handles byte-lane strobes, write-data lane shift, and read-data extract/sign-extend.
//  Sits between the execute stage and the data RAM; holds the core with req_ready until each access completes.
// PARAMETERS
//  ADDR_W  32  byte-address width of req_addr/mem_addr
//  DATA_W  32  data width; fixed at 32, lanes = DATA_W/8 = 4
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   core presents an access
//  req_ready  out  1   unit idle; request is accepted when req_valid && req_ready
//  req_we     in   1   1 = store, 0 = load
//  req_funct3 in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-justified
//  rsp_valid  out  1   one-cycle pulse: access done (no backpressure)
//  rsp_rdata  out  32  load result, extended; 0 for stores and errors
//  rsp_err    out  1   qualified by rsp_valid: illegal funct3, or misaligned access (see CONFIGURATION)
//  mem_addr   out  32  RAM byte address, always word-aligned (addr[1:0]=0)
//  mem_read   out  1   read-beat indicator
//  mem_write  out  4   byte-lane write strobes; RAM writes on the next posedge
//  mem_wdata  out  32  lane-shifted store data
//  mem_rdata  in   32  RAM read data, combinational from mem_addr (same cycle)
// BEHAVIOUR
//  Reset values:
//   - state IDLE, req_ready=1 after reset; req_ready=0 while rst=1
//   - rsp_valid=0, rsp_err=0, rsp_rdata=0
//   - mem_addr=0, mem_read=0, mem_write=0, mem_wdata=0
//  FSM: IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE; req_ready = (state==IDLE).
//   - IDLE: on accept, register we/funct3/addr/wdata; next BEAT0, or RESP with err for illegal funct3/misalign.
//   - BEAT0: drive the word at {addr[31:2],2'b00}; loads capture mem_rdata at the end of the cycle.
//   - BEAT1 (split only): drive word address + 4, wrapping mod 2^32 (0xFFFFFFFC -> 0x00000000).
//   - RESP: rsp_valid=1 for exactly one cycle.
//  Latency: accept in cycle N -> rsp_valid in N+2 (aligned), N+3 (split), N+1 (error).
//   - Next accept is no earlier than RESP+1; throughput is 1 access per 3 cycles when aligned.
//  Strobes: B = 4'b0001<<off; H = 4'b0011<<off; W = 4'b1111 (off = addr[1:0]).
//   - Stores: mem_wdata = req_wdata<<(8*off), asserted in BEAT* only; mem_read=0.
//   - Loads: mem_write=0.
//  Read extract: ({beat1,beat0} >> 8*off), truncated to size.
//   - B/H sign-extend; BU/HU zero-extend.
//  Misaligned: H with off=3; W with off!=0. B is never misaligned.
//  Outside BEAT*: mem_read=0, mem_write=0, mem_wdata=0; mem_addr holds its last value.
//  Errors never issue RAM beats; a store error has no side effects.
//  rst mid-operation: the next state is IDLE; mem_write/mem_read are gated by !rst, so no write in the reset cycle.
//   - A pending rsp is dropped; a store completed in BEAT0 before rst is not undone.
//  req_valid while busy: ignored, not queued; the core holds the request until req_ready.
// CONFIGURATION
//  MISALIGN_SPLIT_EN
//   - Defined: misaligned H/W accesses are split into BEAT0 + BEAT1; rsp_err=0.
//     Store strobes come from the 8-bit mask (size_mask<<off): low nibble -> BEAT0, high nibble -> BEAT1.
//     Store data comes from the 64-bit (wdata<<8*off): low word -> BEAT0, high word -> BEAT1.
//   - Undefined: misaligned -> no RAM beat, rsp_err=1, rsp_rdata=0; BEAT1 state not built.
// STRUCTURE
//  Package lsu_pkg:
//   - funct3 localparams F3_B/H/W/BU/HU
//   - state encoding IDLE/BEAT0/BEAT1/RESP
//   - function size_mask(funct3) -> 4'b0001/0011/1111
//  Sub-module lsu_align (combinational):
//   - inputs: funct3, off, wdata, rdata_lo, rdata_hi
//   - outputs: 8-bit strobe mask, 64-bit shifted wdata, extended rdata
//  load_store_unit holds the FSM, request regs, beat0 capture reg, and port muxing.
// TESTING
//  1 SW 0x0000_1000 data 0xDEAD_BEEF
//    -> BEAT0: mem_addr=0x1000, mem_write=4'hF; rsp_valid at N+2, err=0.
//  2 SB 0x1001 data 0x0000_00A5
//    -> mem_write=4'b0010, mem_wdata=0x0000_A500.
//    Then LB 0x1001 -> rsp_rdata=0xFFFF_FFA5; LBU -> 0x0000_00A5.
//  3 Word 0x1004 holds 0x8001_7FFF: LH 0x1006 -> 0xFFFF_8001; LHU 0x1004 -> 0x0000_7FFF.
//  4 LW 0x1002, words 0x1000=0x4433_2211, 0x1004=0x8877_6655
//    -> with _EN: beats 0x1000/0x1004, rdata=0x6655_4433, rsp at N+3.
//    -> without _EN: no mem_read, rsp_err=1 at N+1.
//  5 SW 0xFFFF_FFFE data 0xAABB_CCDD with _EN
//    -> beat0 0xFFFF_FFFC strobe 4'b1100 wdata 0xCCDD_0000.
//    -> beat1 0x0000_0000 strobe 4'b0011 wdata 0x0000_AABB.
//  6 Illegal funct3=3'b011 -> rsp_err=1, no RAM beat.
//    rst asserted during BEAT0 of a SW -> mem_write=0 that cycle, req_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM encoding and access-size helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] funct3);
    f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  // A halfword only crosses a word at offset 3; bytes never do.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    misaligned = ((funct3[1:0] == 2'b01) && (off == 2'd3)) ||
                 ((funct3[1:0] == 2'b10) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane strobe/data shifting and load extract/extend for the load/store unit
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [7:0]  strb,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [31:0] rd_word;
  logic        unused_hi;

  assign unused_hi = ^rdata_hi[31:24];

  always_comb begin
    strb     = {4'b0000, size_mask(funct3)} << off;
    wdata_sh = {32'h0, wdata} << {off, 3'b000};
    // Window of {hi,lo} starting at byte off; only 3 bytes of hi can ever be reached.
    case (off)
      2'd0:    rd_word = rdata_lo;
      2'd1:    rd_word = {rdata_hi[7:0],  rdata_lo[31:8]};
      2'd2:    rd_word = {rdata_hi[15:0], rdata_lo[31:16]};
      default: rd_word = {rdata_hi[23:0], rdata_lo[31:24]};
    endcase
    case (funct3[1:0])
      2'b00:   rdata_ext = {{24{rd_word[7] & ~funct3[2]}}, rd_word[7:0]};
      2'b01:   rdata_ext = {{16{rd_word[15] & ~funct3[2]}}, rd_word[15:0]};
      default: rdata_ext = rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator driving a word-addressed RAM; MISALIGN_SPLIT_EN enables two-beat misaligned accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic [3:0]        mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        state;
  logic              r_we;
  logic              r_err;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              accept;
  logic              acc_err;
  logic              in_beat;
  logic              last_beat;
  logic [7:0]        strb;
  logic [63:0]       wdata_sh;
  logic [31:0]       rdata_ext;
  logic [31:0]       rd_lo;
  logic [31:0]       rd_hi;

  assign accept = req_valid && req_ready;

`ifdef MISALIGN_SPLIT_EN
  logic        r_split;
  logic [31:0] r_lo;

  assign acc_err   = !f3_legal(req_funct3);
  assign last_beat = (state == S_BEAT1) || !r_split;
  assign rd_lo     = (state == S_BEAT1) ? r_lo : mem_rdata;
  assign rd_hi     = (state == S_BEAT1) ? mem_rdata : 32'h0;
`else
  logic unused_split;

  assign acc_err      = !f3_legal(req_funct3) || misaligned(req_funct3, req_addr[1:0]);
  assign last_beat    = 1'b1;
  assign rd_lo        = mem_rdata;
  assign rd_hi        = 32'h0;
  assign unused_split = ^{strb[7:4], wdata_sh[63:32]};
`endif

  lsu_align u_align (
    .funct3    (r_f3),
    .off       (r_off),
    .wdata     (r_wdata),
    .rdata_lo  (rd_lo),
    .rdata_hi  (rd_hi),
    .strb      (strb),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_f3       <= 3'b000;
      r_off      <= 2'b00;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      mem_addr_q <= '0;
`ifdef MISALIGN_SPLIT_EN
      r_split    <= 1'b0;
      r_lo       <= 32'h0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          r_we    <= req_we;
          r_f3    <= req_funct3;
          r_off   <= req_addr[1:0];
          r_wdata <= req_wdata;
          r_err   <= acc_err;
`ifdef MISALIGN_SPLIT_EN
          r_split <= misaligned(req_funct3, req_addr[1:0]);
`endif
          // Errors skip the RAM entirely, so mem_addr keeps its previous value.
          if (acc_err) begin
            state <= S_RESP;
          end else begin
            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            state      <= S_BEAT0;
          end
        end
        S_BEAT0: begin
`ifdef MISALIGN_SPLIT_EN
          r_lo <= mem_rdata;
`endif
          if (last_beat) begin
            r_rdata <= rdata_ext;
            state   <= S_RESP;
          end else begin
            mem_addr_q <= mem_addr_q + ADDR_W'(4);
            state      <= S_BEAT1;
          end
        end
`ifdef MISALIGN_SPLIT_EN
        S_BEAT1: begin
          r_rdata <= rdata_ext;
          state   <= S_RESP;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_beat   = !rst && ((state == S_BEAT0) || (state == S_BEAT1));
  assign req_ready = !rst && (state == S_IDLE);
  assign rsp_valid = !rst && (state == S_RESP);
  assign rsp_err   = rsp_valid && r_err;
  assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? r_rdata : '0;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = in_beat && !r_we;

  always_comb begin
    mem_write = 4'b0000;
    mem_wdata = '0;
    if (in_beat && r_we) begin
      mem_write = (state == S_BEAT1) ? strb[7:4] : strb[3:0];
      mem_wdata = (state == S_BEAT1) ? wdata_sh[63:32] : wdata_sh[31:0];
    end
  end

endmodule
